// File: rtl/comp2s_arbiter.sv
// comp2s_arbiter: round-robin shared two's-complement negate/abs unit with a one-entry valid/ready output stage
module comp2s_arbiter #(
  parameter int N = 16,
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int SAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [2*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [IDW-1:0]    out_id,
  output logic              out_ovf
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [IDW-1:0] ptr, sel, j;
  logic found, can_accept, gnt, ovf, do_neg, min_neg;
  logic [N-1:0] d, res;
  logic [1:0] op;
  always_comb begin
    found = 1'b0;
    sel = '0;
    j = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[j]) begin
        found = 1'b1;
        sel = j;
      end
    end
  end
  assign can_accept = rst_n && (state == EMPTY || out_ready);
  assign gnt = found && can_accept;
  assign req_ready = gnt ? NREQ'(1) << sel : '0;
  assign out_valid = (state == FULL);
  assign d = req_data[N*int'(sel) +: N];
  assign op = req_op[2*int'(sel) +: 2];
  assign min_neg = (d == {1'b1, {(N-1){1'b0}}});
  assign ovf = min_neg && (op == 2'b01 || op == 2'b10);
  assign do_neg = (op == 2'b01) || (op[1] && (d[N-1] ^ op[0]));
  assign res = (ovf && SAT != 0) ? {1'b0, {(N-1){1'b1}}} : do_neg ? ~d + 1'b1 : d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      ptr <= '0;
      out_data <= '0;
      out_id <= '0;
      out_ovf <= 1'b0;
    end else if (gnt) begin
      state <= FULL;
      ptr <= (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
      out_data <= res;
      out_id <= sel;
      out_ovf <= ovf;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_comp2s_arbiter.sv
// tb_comp2s_arbiter: scoreboard bench for comp2s_arbiter
module tb_comp2s_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b1;
  logic [3:0] req_valid = '0;
  logic [63:0] req_data = '0;
  logic [7:0] req_op = '0;
  logic [3:0] req_ready, req_ready_s;
  logic out_valid, out_valid_s, out_ovf, out_ovf_s;
  logic [15:0] out_data, out_data_s;
  logic [1:0] out_id, out_id_s;
  int total = 0, bad = 0;
  logic [18:0] sb[$];
  int gnt_log[$];
  logic m_full = 1'b0;
  int m_ptr = 0;

  comp2s_arbiter #(.N(16), .NREQ(4), .IDW(2), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_op(req_op),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_ovf(out_ovf));
  comp2s_arbiter #(.N(16), .NREQ(4), .IDW(2), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_op(req_op),
    .req_ready(req_ready_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_id(out_id_s), .out_ovf(out_ovf_s));

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] d, input logic [1:0] op, input bit sat);
    logic [15:0] neg, r;
    logic o;
    neg = 16'(17'h10000 - {1'b0, d});
    o = (d == 16'h8000) && (op == 2'b01 || op == 2'b10);
    case (op)
      2'b00: r = d;
      2'b01: r = neg;
      2'b10: r = d[15] ? neg : d;
      default: r = d[15] ? d : neg;
    endcase
    if (o && sat) r = 16'h7FFF;
    return {o, r};
  endfunction

  always @(negedge clk) begin : mon
    logic acc;
    int gi;
    logic [3:0] e_rdy;
    logic [16:0] m;
    logic [18:0] e;
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr = 0;
      sb.delete();
      total++;
      if (req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL rst_ready got %b want 0000", req_ready);
      end
    end else begin
      acc = !m_full || out_ready;
      gi = -1;
      e_rdy = '0;
      for (int k = 0; k < 4; k++)
        if (gi < 0 && req_valid[(m_ptr + k) % 4]) gi = (m_ptr + k) % 4;
      if (acc && gi >= 0) e_rdy[gi] = 1'b1;
      total++;
      if (req_ready !== e_rdy) begin
        bad++;
        $display("FAIL sb_ready got %b want %b", req_ready, e_rdy);
      end
      total++;
      if (out_valid !== m_full) begin
        bad++;
        $display("FAIL sb_valid got %b want %b", out_valid, m_full);
      end
      if (m_full && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow got output id=%0d with no expected entry", out_id);
        end else begin
          e = sb.pop_front();
          if ({out_ovf, out_id, out_data} !== e) begin
            bad++;
            $display("FAIL sb_result got ovf=%b id=%0d data=%h want ovf=%b id=%0d data=%h",
                     out_ovf, out_id, out_data, e[18], e[17:16], e[15:0]);
          end
        end
      end
      if (acc && gi >= 0) begin
        m = model(req_data[gi*16 +: 16], req_op[gi*2 +: 2], 1'b0);
        sb.push_back({m[16], 2'(gi), m[15:0]});
        gnt_log.push_back(gi);
        m_ptr = (gi + 1) % 4;
      end
      m_full = (acc && gi >= 0) || (m_full && !out_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] d, input logic [1:0] op);
    req_valid[i] = v;
    req_data[i*16 +: 16] = d;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
    step();
    step();
    total++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 16'h0 || out_id !== 2'd0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b v=%b d=%h id=%0d ovf=%b want 0000 0 0000 0 0",
               req_ready, out_valid, out_data, out_id, out_ovf);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    total++;
    if (out_valid !== 1'b1 || out_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_out got v=%b id=%0d want 1 0", out_valid, out_id);
    end
    step();
  endtask

  task automatic test_ops();
    logic [15:0] din[4] = '{16'h0005, 16'hFFFB, 16'h0005, 16'h1234};
    logic [1:0] ops[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [15:0] exp_d[4] = '{16'hFFFB, 16'h0005, 16'hFFFB, 16'h1234};
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(2, 1'b1, din[t], ops[t]);
      #1;
      total++;
      if (req_ready !== 4'b0100) begin
        bad++;
        $display("FAIL ops_ready[%0d] got %b want 0100", t, req_ready);
      end
      step();
      set_req(2, 1'b0, 16'h0, 2'b00);
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== exp_d[t] || out_ovf !== 1'b0) begin
        bad++;
        $display("FAIL ops_result[%0d] got v=%b id=%0d d=%h ovf=%b want 1 2 %h 0",
                 t, out_valid, out_id, out_data, out_ovf, exp_d[t]);
      end
      step();
    end
  endtask

  task automatic test_ovf();
    logic [1:0] ops[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [15:0] exp_w[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    logic [15:0] exp_s[4] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    logic exp_o[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(0, 1'b1, 16'h8000, ops[t]);
      step();
      set_req(0, 1'b0, 16'h0, 2'b00);
      total++;
      if (out_data !== exp_w[t] || out_ovf !== exp_o[t]) begin
        bad++;
        $display("FAIL ovf_wrap[%0d] got d=%h ovf=%b want %h %b", t, out_data, out_ovf, exp_w[t], exp_o[t]);
      end
      total++;
      if (out_data_s !== exp_s[t] || out_ovf_s !== exp_o[t]) begin
        bad++;
        $display("FAIL ovf_sat[%0d] got d=%h ovf=%b want %h %b", t, out_data_s, out_ovf_s, exp_s[t], exp_o[t]);
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    int exp1[6] = '{0, 1, 2, 3, 0, 1};
    int exp2[6] = '{0, 2, 3, 0, 2, 3};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'($urandom), 2'($urandom));
    pulse_reset();
    gnt_log.delete();
    repeat (6) step();
    total++;
    if (gnt_log.size() != 6) begin
      bad++;
      $display("FAIL rr_all_count got %0d want 6", gnt_log.size());
    end else
      for (int k = 0; k < 6; k++) begin
        total++;
        if (gnt_log[k] != exp1[k]) begin
          bad++;
          $display("FAIL rr_all[%0d] got %0d want %0d", k, gnt_log[k], exp1[k]);
        end
      end
    pulse_reset();
    req_valid[1] = 1'b0;
    gnt_log.delete();
    repeat (6) step();
    total++;
    if (gnt_log.size() != 6) begin
      bad++;
      $display("FAIL rr_drop_count got %0d want 6", gnt_log.size());
    end else
      for (int k = 0; k < 6; k++) begin
        total++;
        if (gnt_log[k] != exp2[k]) begin
          bad++;
          $display("FAIL rr_drop[%0d] got %0d want %0d", k, gnt_log[k], exp2[k]);
        end
      end
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    pulse_reset();
    set_req(0, 1'b1, 16'h0042, 2'b01);
    step();
    set_req(0, 1'b0, 16'h0, 2'b00);
    set_req(1, 1'b1, 16'h00A0, 2'b10);
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 16'hFFBE) begin
        bad++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b id=%0d d=%h want 0000 1 0 ffbe",
                 c, req_ready, out_valid, out_id, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL bp_release_ready got %b want 0010", req_ready);
    end
    step();
    set_req(1, 1'b0, 16'h0, 2'b00);
    total++;
    if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 16'h00A0) begin
      bad++;
      $display("FAIL bp_next got v=%b id=%0d d=%h want 1 1 00a0", out_valid, out_id, out_data);
    end
    step();
    total++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain got pending=%0d v=%b want 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_req(2, 1'b1, 16'h0007, 2'b01);
    step();
    set_req(2, 1'b0, 16'h0, 2'b00);
    total++;
    if (out_valid !== 1'b1 || out_id !== 2'd2) begin
      bad++;
      $display("FAIL mid_full got v=%b id=%0d want 1 2", out_valid, out_id);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_id !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset got v=%b d=%h id=%0d want 0 0000 0", out_valid, out_data, out_id);
    end
    rst_n = 1'b1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_ptr got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    total++;
    if (out_id !== 2'd0) begin
      bad++;
      $display("FAIL mid_next_id got %0d want 0", out_id);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] hs = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] || hs[i])
          set_req(i, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom), 2'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hs = req_valid & req_ready;
      step();
    end
    req_valid = '0;
    out_ready = 1'b1;
    repeat (3) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_pending got %0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_ovf();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/comp2s_arbiter.md
# comp2s_arbiter

Round-robin scheduler that shares a single two's-complement negation datapath among NREQ requesters in the ELM fixed-point pipeline. Each requester presents a Q-format word and an opcode (pass, negate, absolute value, negative absolute value). The block grants one request per cycle, computes the result through the shared 2's-complement path, and returns it from a one-entry registered output stage with a valid/ready handshake, tagged with the requester ID.

## Interface
- N, 16, data word width (two's-complement)
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, ceil(log2(NREQ))
- SAT, 0, 1 = saturate the most-negative input to +max on negate/abs; 0 = wrap
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_data  input  NREQ*N  requester i word at [i*N +: N]
- req_op  input  2*NREQ  requester i op at [2i +: 2]: 00 pass, 01 negate, 10 abs, 11 -abs
- req_ready  output  NREQ  one-hot grant; request i consumed when req_valid[i] & req_ready[i]
- out_valid  output  1  result register holds a result
- out_ready  input  1  downstream accepts the result
- out_data  output  N  result word
- out_id  output  IDW  index of the requester that produced out_data
- out_ovf  output  1  input was 2^(N-1) negative-max and op was 01 or 10

## Operation
- Negation: (2^N − data) truncated to N bits; equivalent to ~data+1.
- Op results: 00 → data; 01 → −data; 10 → data[N-1] ? −data : data; 11 → data[N-1] ? data : −data.
- Most-negative input 0x8000 (N=16): ops 01/10 set out_ovf=1; out_data = 0x8000 if SAT=0, 0x7FFF if SAT=1. Op 11 gives 0x8000, out_ovf=0. Op 00 never flags.
- Output stage is a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - can_accept = EMPTY | out_ready.
  - EMPTY + grant → FULL; FULL + out_ready + no grant → EMPTY; FULL + out_ready + grant → FULL with new result; FULL + !out_ready → FULL, held.
- Arbitration: round-robin pointer ptr (reset 0). Search starts at ptr, scans ascending modulo NREQ, and picks the first i with req_valid[i]. req_ready[i]=1 only for that i, and only when can_accept. All zero otherwise.
- On a grant to i, ptr ← (i+1) mod NREQ. Without a grant, ptr holds.
- req_ready is combinational from req_valid, out_ready and state. Requesters must not make req_valid depend on req_ready. Each requester holds data and op stable while valid and not granted.
- out_data, out_id and out_ovf change only on a grant. They are stable while FULL and !out_ready.

## Timing
- Reset (rst_n=0 at a clock edge): out_valid=0, out_data=0, out_id=0, out_ovf=0, ptr=0, state EMPTY. req_ready is 0 while rst_n=0.
- Reset applied mid-operation discards the held result and any in-flight grant. No output appears for it.
- Latency: request granted in cycle t → result visible with out_valid=1 from cycle t+1.
- Throughput: one result per cycle while out_ready=1 continuously. There are no bubbles in the pass-through case (FULL & out_ready & grant).
- Backpressure: out_ready=0 while FULL forces req_ready=0 on the same cycle.
- Fairness: any requester holding req_valid high is granted within NREQ grants.
- req_valid rising in the same cycle as a grant to another requester does not alter that grant.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with all req_valid=1 → req_ready=0, out_valid=0, out_data=0, out_id=0; first grant after release goes to requester 0.
- Single op sweep on requester 2 with out_ready=1: 0x0005/op01 → 0xFFFB; 0xFFFB/op10 → 0x0005; 0x0005/op11 → 0xFFFB; 0x1234/op00 → 0x1234. Each result is out_id=2, one cycle after grant.
- Overflow: 0x8000/op01 with SAT=0 → 0x8000, out_ovf=1. Same with SAT=1 → 0x7FFF, out_ovf=1. 0x8000/op11 → 0x8000, out_ovf=0.
- Round-robin: all four requesters valid continuously, out_ready=1 → grant order 0,1,2,3,0,1, one per cycle. Drop req_valid[1] → order 0,2,3,0,2,3.
- Backpressure: FULL with out_id=0 and out_ready=0 for 5 cycles → out_data/out_id stable, req_ready=0. Raise out_ready → held result consumed, next result (requester 1) in the same cycle's pass-through, with no lost or duplicated result.
- Reset mid-stream: assert rst_n=0 while FULL and out_ready=0 → next cycle out_valid=0 and ptr=0; the held result is never delivered.
